// File: rtl/input_bank_if.sv
// LSU load/store bus of the input bank: the LSU drives requests (master), input_bank answers (slave).
interface input_bank_if;
    logic        i_lsu_rden;
    logic        i_lsu_wren;
    logic [31:0] i_lsu_addr;
    logic [31:0] i_st_data;
    logic [2:0]  funct3;
    logic        input_buf_en;
    logic [31:0] o_ld_data;

    modport master (
        output i_lsu_rden, i_lsu_wren, i_lsu_addr, i_st_data, funct3, input_buf_en,
        input  o_ld_data
    );

    modport slave (
        input  i_lsu_rden, i_lsu_wren, i_lsu_addr, i_st_data, funct3, input_buf_en,
        output o_ld_data
    );
endinterface

// File: rtl/input_bank.sv
// Memory-mapped switch/button input bank for the LSU: synchronised switches, debounced buttons,
// sticky W1C press flags and a press counter. Define INPUT_BANK_IRQ_EN for IRQ_MASK and o_irq.
module input_bank #(
    parameter int SW_WIDTH        = 32,
    parameter int NUM_BTN         = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input_bank_if.slave         bus,
    input  logic [SW_WIDTH-1:0] i_io_sw,
    input  logic [NUM_BTN-1:0]  i_io_btn
`ifdef INPUT_BANK_IRQ_EN
    ,
    output logic                o_irq
`endif
);
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [2:0] W_SW       = 3'd0;
    localparam logic [2:0] W_BTN_LVL  = 3'd4;
    localparam logic [2:0] W_BTN_EVT  = 3'd5;
    localparam logic [2:0] W_EVT_CNT  = 3'd6;
    localparam logic [2:0] W_IRQ_MASK = 3'd7;

    function automatic logic [15:0] count_ones(input logic [NUM_BTN-1:0] v);
        logic [15:0] n;
        n = '0;
        for (int i = 0; i < NUM_BTN; i++) n = n + 16'(v[i]);
        return n;
    endfunction

    function automatic logic [3:0] store_lanes(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            3'd0:    store_lanes = 4'b0001 << off;
            3'd1:    store_lanes = off[1] ? 4'b1100 : 4'b0011;
            3'd2:    store_lanes = 4'b1111;
            default: store_lanes = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [2:0] f3,
                                                 input logic [1:0] off);
        logic        [7:0]  b;
        logic        [15:0] h;
        logic signed [7:0]  sb;
        logic signed [15:0] sh;
        logic signed [31:0] sx;
        b  = word[{off, 3'b000} +: 8];
        h  = off[1] ? word[31:16] : word[15:0];
        sb = b;
        sh = h;
        case (f3)
            3'd0:    begin sx = sb; load_extract = sx; end
            3'd1:    begin sx = sh; load_extract = sx; end
            3'd2:    load_extract = word;
            3'd4:    load_extract = {24'd0, b};
            3'd5:    load_extract = {16'd0, h};
            default: load_extract = '0;
        endcase
    endfunction

    logic [SW_WIDTH-1:0]                sw_p0, sw_p1;
    logic [NUM_BTN-1:0]                 btn_p0, btn_p1;
    logic [NUM_BTN-1:0]                 btn_lvl, btn_lvl_nxt, btn_rise;
    logic [NUM_BTN-1:0][CNT_W-1:0]      db_cnt, db_cnt_nxt;
    logic [NUM_BTN-1:0]                 btn_evt, btn_evt_nxt, evt_clr;
    logic [15:0]                        evt_cnt, evt_cnt_nxt, rise_cnt;
    logic                               st_en, cnt_clr;
    logic [3:0]                         lanes;
    logic [2:0]                         wsel;
    logic [31:0]                        rd_word, mask_word;

    assign wsel  = bus.i_lsu_addr[4:2];
    assign st_en = bus.input_buf_en & bus.i_lsu_wren & i_rst_n;
    assign lanes = st_en ? store_lanes(bus.funct3, bus.i_lsu_addr[1:0]) : 4'b0000;

    // Debounce: a level is accepted after DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
        btn_lvl_nxt = btn_lvl;
        db_cnt_nxt  = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (btn_p1[i] != btn_lvl[i]) begin
                if (db_cnt[i] == CNT_LAST) btn_lvl_nxt[i] = btn_p1[i];
                else                       db_cnt_nxt[i]  = db_cnt[i] + 1'b1;
            end
        end
    end

    assign btn_rise = btn_lvl_nxt & ~btn_lvl;
    assign rise_cnt = count_ones(btn_rise);

    // New presses are OR-ed in after the W1C so a same-cycle set survives the clear.
    assign evt_clr     = (wsel == W_BTN_EVT && lanes[0]) ? bus.i_st_data[NUM_BTN-1:0] : '0;
    assign btn_evt_nxt = (btn_evt & ~evt_clr) | btn_rise;
    assign cnt_clr     = (wsel == W_EVT_CNT) && (lanes[0] || lanes[1]);
    assign evt_cnt_nxt = cnt_clr ? rise_cnt : evt_cnt + rise_cnt;

    // Stage boundary: pins -> _p0 -> _p1 synchronisers, then debounced state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sw_p0   <= '0;
            sw_p1   <= '0;
            btn_p0  <= '0;
            btn_p1  <= '0;
            btn_lvl <= '0;
            db_cnt  <= '0;
            btn_evt <= '0;
            evt_cnt <= '0;
        end else begin
            sw_p0   <= i_io_sw;
            sw_p1   <= sw_p0;
            btn_p0  <= i_io_btn;
            btn_p1  <= btn_p0;
            btn_lvl <= btn_lvl_nxt;
            db_cnt  <= db_cnt_nxt;
            btn_evt <= btn_evt_nxt;
            evt_cnt <= evt_cnt_nxt;
        end
    end

`ifdef INPUT_BANK_IRQ_EN
    logic [NUM_BTN-1:0] irq_mask;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            irq_mask <= '0;
            o_irq    <= 1'b0;
        end else begin
            if (wsel == W_IRQ_MASK && lanes[0]) irq_mask <= bus.i_st_data[NUM_BTN-1:0];
            o_irq <= |(btn_evt & irq_mask);
        end
    end

    assign mask_word = 32'(irq_mask);
`else
    assign mask_word = '0;
`endif

    always_comb begin
        rd_word = '0;
        case (wsel)
            W_SW:       rd_word = 32'(sw_p1);
            W_BTN_LVL:  rd_word = 32'(btn_lvl);
            W_BTN_EVT:  rd_word = 32'(btn_evt);
            W_EVT_CNT:  rd_word = 32'(evt_cnt);
            W_IRQ_MASK: rd_word = mask_word;
            default:    rd_word = '0;
        endcase
    end

    assign bus.o_ld_data = (bus.input_buf_en && bus.i_lsu_rden)
                         ? load_extract(rd_word, bus.funct3, bus.i_lsu_addr[1:0]) : '0;

    logic unused_bits;
    assign unused_bits = &{1'b0, bus.i_lsu_addr[31:5], bus.i_st_data[31:NUM_BTN], lanes[3:2]};
endmodule
